// File: rtl/seq_pkg.sv
// Shared definitions for the 1101 pattern transmitter and its companion detector.
package seq_pkg;

  // Pattern frame width and the frame itself, sent MSB first.
  localparam int unsigned PAT_W = 4;
  localparam logic [PAT_W-1:0] PAT = 4'b1101;

  // Bit index at which overlapped frames restart (the leading 1 is shared).
  localparam logic [1:0] OVL_START = 2'd1;

  // Index of the final bit within a frame.
  localparam logic [1:0] LAST_IDX = 2'(PAT_W - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPat  = 2'd1,
    StGap  = 2'd2
  } seq_state_e;

  // Pattern bit at frame index idx (index 0 is the MSB).
  function automatic logic pat_bit(input logic [1:0] idx);
    logic [1:0] pos;
    pos = LAST_IDX - idx;
    return PAT[pos];
  endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial burst generator: emits count frames of 1101 with optional zero gaps
// or overlapped frames, with busy framing and a one-cycle done pulse.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             overlap,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  seq_state_e       state_q;
  logic [1:0]       idx_q;      // bit index of the frame bit currently on dout
  logic [CNT_W-1:0] frames_q;   // frames still to send after the current one
  logic [GAP_W-1:0] gap_len_q;  // latched gap length
  logic [GAP_W-1:0] gap_cnt_q;  // gap cycles left, including the current one
  logic             ovl_q;      // latched overlap request
  logic             dout_q;
  logic             busy_q;
  logic             done_q;

  // Burst FSM with registered outputs; every output reflects the state entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      frames_q  <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      ovl_q     <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          dout_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            if (count != '0) begin
              state_q   <= StPat;
              idx_q     <= '0;
              dout_q    <= pat_bit(2'd0);
              busy_q    <= 1'b1;
              frames_q  <= count - 1'b1;
              gap_len_q <= gap;
              ovl_q     <= overlap;
            end else begin
              // Empty burst: nothing sent, completion still signalled.
              done_q <= 1'b1;
            end
          end
        end

        StPat: begin
          if (idx_q != LAST_IDX) begin
            idx_q  <= idx_q + 2'd1;
            dout_q <= pat_bit(idx_q + 2'd1);
          end else if (frames_q != '0) begin
            frames_q <= frames_q - 1'b1;
            if (gap_len_q != '0) begin
              state_q   <= StGap;
              gap_cnt_q <= gap_len_q;
              dout_q    <= 1'b0;
            end else if (ovl_q) begin
              // Back-to-back overlapped frame reuses the previous trailing 1.
              idx_q  <= OVL_START;
              dout_q <= pat_bit(OVL_START);
            end else begin
              idx_q  <= '0;
              dout_q <= pat_bit(2'd0);
            end
          end else begin
            state_q <= StIdle;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        StGap: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= StPat;
            idx_q   <= '0;
            dout_q  <= pat_bit(2'd0);
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a queue-based burst model checked every cycle,
// directed bursts pinned by literal expectations, then randomized traffic.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic [3:0] gap;
  logic       overlap;
  logic       dout;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  // Model: queue of upcoming {dout, busy, done} triples for the active burst.
  logic [2:0]  q[$];
  logic [2:0]  exp_q;
  logic [31:0] hist;
  int          busy_cnt;

  seq_pattern_tx #(
    .CNT_W(4),
    .GAP_W(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .count  (count),
    .gap    (gap),
    .overlap(overlap),
    .dout   (dout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build the whole burst from the frame/gap rules.
  task automatic build_burst(input logic [3:0] c, input logic [3:0] g, input logic o);
    for (int f = 0; f < int'(c); f++) begin
      if (f > 0) begin
        for (int k = 0; k < int'(g); k++) q.push_back(3'b010);
      end
      if (f > 0 && o && g == 4'd0) begin
        q.push_back(3'b110); q.push_back(3'b010); q.push_back(3'b110);
      end else begin
        q.push_back(3'b110); q.push_back(3'b110); q.push_back(3'b010); q.push_back(3'b110);
      end
    end
    q.push_back(3'b001);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare just after.
  task automatic step(input logic r, input logic s, input logic [3:0] c,
                      input logic [3:0] g, input logic o);
    rst = r; start = s; count = c; gap = g; overlap = o;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_q = 3'b000;
    end else if (q.size() != 0) begin
      exp_q = q.pop_front();
    end else if (s) begin
      build_burst(c, g, o);
      exp_q = q.pop_front();
    end else begin
      exp_q = 3'b000;
    end
    #1;
    checks++;
    if ({dout, busy, done} !== exp_q) begin
      errors++;
      $display("FAIL cycle_model t=%0t: dout/busy/done got %b%b%b expected %b",
               $time, dout, busy, done, exp_q);
    end
    hist = {hist[30:0], dout};
    busy_cnt += int'(busy);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  initial begin
    checks = 0; errors = 0; hist = '0; busy_cnt = 0; exp_q = '0;
    rst = 1'b1; start = 1'b0; count = '0; gap = '0; overlap = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 4'd3, 4'd0, 1'b0);
    check("reset_outputs", {29'd0, dout, busy, done}, 32'd0);
    idle(2);

    // count=2, gap=0, no overlap
    hist = '0; busy_cnt = 0;
    step(1'b0, 1'b1, 4'd2, 4'd0, 1'b0);
    idle(7);
    check("c2g0_dout", hist & 32'hFF, 32'b11011101);
    check("c2g0_busy", busy_cnt, 8);
    idle(1);
    check("c2g0_done", {30'd0, busy, done}, 32'b01);

    // count=3, overlap with gap=0
    hist = '0; busy_cnt = 0;
    step(1'b0, 1'b1, 4'd3, 4'd0, 1'b1);
    idle(9);
    check("c3ovl_dout", hist & 32'h3FF, 32'b1101101101);
    check("c3ovl_busy", busy_cnt, 10);
    idle(1);
    check("c3ovl_done", {31'd0, done}, 32'd1);

    // count=2, gap=2, overlap ignored
    hist = '0; busy_cnt = 0;
    step(1'b0, 1'b1, 4'd2, 4'd2, 1'b1);
    idle(9);
    check("c2g2_dout", hist & 32'h3FF, 32'b1101001101);
    check("c2g2_busy", busy_cnt, 10);
    idle(1);
    check("c2g2_done", {31'd0, done}, 32'd1);

    // count=0: done only
    idle(1);
    step(1'b0, 1'b1, 4'd0, 4'd5, 1'b0);
    check("c0_done", {29'd0, dout, busy, done}, 32'b001);
    idle(1);
    check("c0_after", {29'd0, dout, busy, done}, 32'b000);

    // Reset mid-burst, then a normal burst
    step(1'b0, 1'b1, 4'd3, 4'd0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 4'd3, 4'd0, 1'b0);
    check("rst_abort", {29'd0, dout, busy, done}, 32'b000);
    idle(1);
    check("rst_no_done", {31'd0, done}, 32'd0);
    hist = '0;
    step(1'b0, 1'b1, 4'd1, 4'd0, 1'b0);
    idle(4);
    check("post_rst_burst", hist & 32'h1F, 32'b11010);

    // start held with count=1: back-to-back bursts with one done cycle between
    hist = '0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'd1, 4'd0, 1'b0);
    check("held_start", hist & 32'h3FF, 32'b1101011010);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, s, o;
      logic [3:0] c, g;
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      g = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) g = 4'd15;
      o = 1'($urandom);
      step(r, s, c, g, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the frame count input.
REQ-002 SHALL have parameter GAP_W, default 4, width of the gap length input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port count  input  CNT_W  number of pattern frames in the burst; latched on an accepted start.
REQ-007 SHALL have port gap  input  GAP_W  number of 0 bits between frames; latched on an accepted start.
REQ-008 SHALL have port overlap  input  1  1 = frames share the leading 1 when gap==0; latched on an accepted start.
REQ-009 SHALL have port dout  output  1  registered serial bit stream, one bit per clk cycle.
REQ-010 SHALL have port busy  output  1  high on every cycle that dout carries burst bits (pattern or gap).
REQ-011 SHALL have port done  output  1  one-cycle pulse marking burst completion.

Function
REQ-012 SHALL emit pattern 1101 MSB-first per frame; this is the stream consumed by the team's overlapping Mealy 1101 detector.
REQ-013 SHALL implement FSM states IDLE, PAT (bit index 0..3), GAP, and SHALL use no other states.
REQ-014 IDLE: dout=0, busy=0; an edge with start=1 and count!=0 moves to PAT and latches count/gap/overlap.
REQ-015 Latency: dout SHALL present the first pattern bit (1) in the cycle right after the edge that accepted start.
REQ-016 PAT: each edge advances one bit; after bit 3, if frames remain -> GAP when gap!=0, else next frame starts.
REQ-017 Overlap (overlap=1, gap==0): frames after the first SHALL start at bit index 1, emitting only 101.
REQ-018 overlap=1 with gap!=0 SHALL emit full 1101 frames; overlap SHALL then have no effect.
REQ-019 GAP: dout=0, busy=1 for exactly gap cycles, then next frame bit 0; no gap after the last frame.
REQ-020 Burst length in cycles SHALL be 4+3*(count-1) when overlap=1 and gap=0, else 4*count+gap*(count-1).
REQ-021 After the last bit: next cycle IDLE, busy=0, dout=0, done=1 for exactly that one cycle.
REQ-022 start=1 with count==0 SHALL produce no bits and a done pulse in the next cycle.
REQ-023 start while busy SHALL be ignored, and inputs changing mid-burst SHALL have no effect.
REQ-024 start high in the done cycle SHALL be accepted, giving back-to-back bursts with one idle cycle between them.
REQ-025 Frame and gap counters SHALL not wrap: count max 2^CNT_W-1 frames, gap max 2^GAP_W-1 cycles.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, dout=0, busy=0, done=0 and clear latched count/gap/overlap, regardless of state.
REQ-027 Reset mid-burst SHALL abort it without a done pulse; rst SHALL take priority over start on the same edge.

Structure
REQ-028 Shared package seq_pkg SHALL hold PAT_W=4, PAT=4'b1101, OVL_START=1 and the FSM state encoding, shared with the detector.
REQ-029 Single module, no sub-module; frame counter, gap counter and bit index SHALL be inline registers.

Verification
REQ-030 start, count=2, gap=0, overlap=0 -> dout 11011101, busy 8 cycles, done on cycle 9; detector y pulses 2x.
REQ-031 start, count=3, gap=0, overlap=1 -> dout 1101101101 (10 cycles), then done; detector y pulses 3x.
REQ-032 start, count=2, gap=2, overlap=1 -> dout 1101001101 (10 cycles), busy high throughout, including gap zeros.
REQ-033 start, count=0 -> busy stays 0, dout 0, done pulse one cycle after start.
REQ-034 count=3, gap=0, rst asserted at edge 5 of burst -> next cycle dout=0, busy=0, no done; new start works normally.
REQ-035 start held high continuously, count=1 -> bursts 1101, 0 (done cycle), 1101, ...; start pulses during busy ignored.
